// File: rtl/bubble_access_sequencer_if.sv
// Page-load channel between the bubble access sequencer (master) and the SPI page loader (slave).
interface bubble_access_sequencer_if #(
    parameter int unsigned POS_W = 12
);
    logic             load_req;
    logic [POS_W-1:0] load_page;
    logic             load_boot;
    logic             load_ack;

    modport master (
        output load_req,
        output load_page,
        output load_boot,
        input  load_ack
    );

    modport slave (
        input  load_req,
        input  load_page,
        input  load_boot,
        output load_ack
    );
endinterface

// File: rtl/bubble_access_sequencer.sv
// Bubble page access sequencer: host strobe sync, loop position, page load request and output window.
// Optional build macro ACCESS_TIMEOUT_EN bounds the wait for load_ack and reports timeout_err.
module bubble_access_sequencer #(
    parameter int unsigned POSITIONS       = 2053,
    parameter int unsigned POS_W           = 12,
    parameter int unsigned REPLICATE_DELAY = 100,
    parameter int unsigned OUTPUT_BITS     = 584,
    parameter int unsigned TIMEOUT_CYCLES  = 65535
) (
    input  logic                      master_clock,
    input  logic                      power_good,
    input  logic                      bubble_shift_enable,
    input  logic                      replicator_enable,
    input  logic                      bootloop_enable,
    input  logic                      field_tick,
    bubble_access_sequencer_if.master load_if,
    output logic                      output_window,
    output logic [9:0]                bit_index,
    output logic [POS_W-1:0]          position,
    output logic                      overrun,
    output logic                      timeout_err
);

    localparam int unsigned BIT_W = 10;
    localparam int unsigned DLY_W = $clog2(REPLICATE_DELAY + 1);

    // Reject parameter sets the fixed-width fields cannot represent.
    if ((64'd1 << POS_W) < 64'(POSITIONS) || OUTPUT_BITS == 0 || OUTPUT_BITS > (1 << BIT_W) ||
        REPLICATE_DELAY == 0 || TIMEOUT_CYCLES == 0) begin : g_bad_cfg
        $error("bubble_access_sequencer: invalid parameter set");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_DELAY,
        S_WINDOW
    } state_e;

    logic             shift_meta_q, shift_sync_q;
    logic             rep_meta_q, rep_sync_q, rep_dly_q;
    logic             boot_meta_q, boot_sync_q;
    logic             shift_active;
    logic             rep_edge;

    state_e           state_q;
    logic             load_req_q;
    logic [POS_W-1:0] load_page_q;
    logic             load_boot_q;
    logic [DLY_W-1:0] dly_cnt_q;
    logic             window_q;
    logic [BIT_W-1:0] bit_idx_q;
    logic [POS_W-1:0] pos_q;
    logic [POS_W-1:0] pos_d;
    logic             overrun_q;

`ifdef ACCESS_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0] tmo_cnt_q;
    logic             timeout_err_q;
`endif

    // Two-flop synchronisers; reset parks every strobe at its inactive level.
    always_ff @(posedge master_clock or negedge power_good) begin
        if (!power_good) begin
            shift_meta_q <= 1'b1;
            shift_sync_q <= 1'b1;
            rep_meta_q   <= 1'b1;
            rep_sync_q   <= 1'b1;
            rep_dly_q    <= 1'b1;
            boot_meta_q  <= 1'b0;
            boot_sync_q  <= 1'b0;
        end else begin
            shift_meta_q <= bubble_shift_enable;
            shift_sync_q <= shift_meta_q;
            rep_meta_q   <= replicator_enable;
            rep_sync_q   <= rep_meta_q;
            rep_dly_q    <= rep_sync_q;
            boot_meta_q  <= bootloop_enable;
            boot_sync_q  <= boot_meta_q;
        end
    end

    assign shift_active = ~shift_sync_q;
    assign rep_edge     = rep_dly_q & ~rep_sync_q;

    always_comb begin
        pos_d = pos_q;
        if (shift_active && field_tick) begin
            pos_d = (pos_q == POS_W'(POSITIONS - 1)) ? '0 : pos_q + POS_W'(1);
        end
    end

    // Loop position survives shift release; only reset returns it to zero.
    always_ff @(posedge master_clock or negedge power_good) begin
        if (!power_good) begin
            pos_q <= '0;
        end else begin
            pos_q <= pos_d;
        end
    end

    always_ff @(posedge master_clock or negedge power_good) begin
        if (!power_good) begin
            state_q       <= S_IDLE;
            load_req_q    <= 1'b0;
            load_page_q   <= '0;
            load_boot_q   <= 1'b0;
            dly_cnt_q     <= '0;
            window_q      <= 1'b0;
            bit_idx_q     <= '0;
            overrun_q     <= 1'b0;
`ifdef ACCESS_TIMEOUT_EN
            tmo_cnt_q     <= '0;
            timeout_err_q <= 1'b0;
`endif
        end else begin
            if (rep_edge && state_q != S_IDLE) begin
                overrun_q <= 1'b1;
            end

            case (state_q)
                S_IDLE: begin
                    // pos_q is the pre-increment position even if field_tick is high now.
                    if (rep_edge && shift_active) begin
                        load_page_q <= pos_q;
                        load_boot_q <= ~boot_sync_q;
                        load_req_q  <= 1'b1;
`ifdef ACCESS_TIMEOUT_EN
                        tmo_cnt_q   <= '0;
`endif
                        state_q     <= S_LOAD;
                    end
                end

                S_LOAD: begin
                    if (!shift_active) begin
                        load_req_q <= 1'b0;
                        state_q    <= S_IDLE;
                    end else if (load_if.load_ack) begin
                        load_req_q <= 1'b0;
                        dly_cnt_q  <= '0;
                        state_q    <= S_DELAY;
                    end
`ifdef ACCESS_TIMEOUT_EN
                    else if (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                        timeout_err_q <= 1'b1;
                        load_req_q    <= 1'b0;
                        state_q       <= S_IDLE;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);
                    end
`endif
                end

                S_DELAY: begin
                    if (!shift_active) begin
                        state_q <= S_IDLE;
                    end else if (field_tick) begin
                        if (dly_cnt_q == DLY_W'(REPLICATE_DELAY - 1)) begin
                            window_q  <= 1'b1;
                            bit_idx_q <= '0;
                            state_q   <= S_WINDOW;
                        end else begin
                            dly_cnt_q <= dly_cnt_q + DLY_W'(1);
                        end
                    end
                end

                S_WINDOW: begin
                    if (!shift_active) begin
                        window_q  <= 1'b0;
                        bit_idx_q <= '0;
                        state_q   <= S_IDLE;
                    end else if (field_tick) begin
                        if (bit_idx_q == BIT_W'(OUTPUT_BITS - 1)) begin
                            window_q  <= 1'b0;
                            bit_idx_q <= '0;
                            state_q   <= S_IDLE;
                        end else begin
                            bit_idx_q <= bit_idx_q + BIT_W'(1);
                        end
                    end
                end

                default: begin
                    load_req_q <= 1'b0;
                    window_q   <= 1'b0;
                    bit_idx_q  <= '0;
                    state_q    <= S_IDLE;
                end
            endcase
        end
    end

    assign load_if.load_req  = load_req_q;
    assign load_if.load_page = load_page_q;
    assign load_if.load_boot = load_boot_q;
    assign output_window     = window_q;
    assign bit_index         = bit_idx_q;
    assign position          = pos_q;
    assign overrun           = overrun_q;

`ifdef ACCESS_TIMEOUT_EN
    assign timeout_err = timeout_err_q;
`else
    assign timeout_err = 1'b0;
`endif

endmodule

// File: doc/bubble_access_sequencer.md
Name: bubble_access_sequencer

Overview:
Sequences emulated bubble-memory page accesses between the host bubble interface and the SPI flash page loader. Synchronises the host's active-low shift and replicator strobes and tracks the rotating-field loop position. When the host replicates, it requests the matching page from the loader, then opens the bit-output window used by the odd/even bubble output shifter. Sits between the timing generator, the SPI loader and the output serializer inside the top level.

Parameters:
POSITIONS, 2053, loop positions per minor loop; position counter wraps at POSITIONS-1
POS_W, 12, width of position/page fields (must satisfy 2^POS_W >= POSITIONS)
REPLICATE_DELAY, 100, field ticks from replicator edge to first output bit
OUTPUT_BITS, 584, field ticks the output window stays open per page
TIMEOUT_CYCLES, 65535, master_clock cycles allowed for load_ack (optional feature only)

Ports:
master_clock  in  1  system clock
power_good  in  1  asynchronous active-low reset
bubble_shift_enable  in  1  host shift enable, active low, asynchronous
replicator_enable  in  1  host replicator strobe, active low, asynchronous
bootloop_enable  in  1  high = user area, low = bootloader loop, asynchronous
field_tick  in  1  one-cycle pulse per rotating-field step, from timing generator
load_req  out  1  page load request to SPI loader
load_page  out  POS_W  page number to load (valid while load_req=1)
load_boot  out  1  1 = load from bootloader region
load_ack  in  1  one-cycle pulse: page buffer ready
output_window  out  1  high while the serializer may emit bits
bit_index  out  10  index of current output bit within window
position  out  POS_W  current loop position
overrun  out  1  sticky: replicate arrived while busy
timeout_err  out  1  sticky: load_ack timeout (0 unless feature enabled)

Behaviour:
- Reset (power_good=0, async): all outputs 0; state IDLE; synchronisers cleared to inactive (shift/replicator regs = 1, bootloop = 0).
- bubble_shift_enable, replicator_enable and bootloop_enable each pass through 2-FF synchronisers; all decisions use the synchronised values. This adds 2 cycles of latency.
- Replicator edge = synchronised falling edge, detected one cycle after the sync output changes.
- Position counter: +1 on field_tick while shift_active = ~sync_shift. Wraps POSITIONS-1 -> 0. Holds when shift is inactive and is not reset by shift release.
- States: IDLE, LOAD, DELAY, WINDOW.
- IDLE: replicator edge with shift_active -> latch load_page = position and load_boot = ~sync_bootloop; assert load_req; go to LOAD. Replicator edge without shift_active -> ignored.
- LOAD: hold load_req until a cycle with load_ack=1. Drop load_req the next cycle. Clear the delay counter; go to DELAY.
- DELAY: count field_tick up to REPLICATE_DELAY, then go to WINDOW with bit_index=0.
- WINDOW: output_window=1; bit_index +1 per field_tick. On the tick where bit_index = OUTPUT_BITS-1, clear output_window and bit_index next cycle; go to IDLE.
- Replicator edge in LOAD/DELAY/WINDOW -> set overrun (sticky until reset); the access in progress continues unaffected.
- Shift inactive in LOAD/DELAY/WINDOW -> abort on the next cycle: load_req=0, output_window=0, bit_index=0, IDLE. A load_ack arriving after an abort is ignored.
- load_ack outside LOAD is ignored.
- If field_tick and a replicator edge occur in the same IDLE cycle, load_page takes the pre-increment position.
- bootloop changes only take effect at the next latch; load_boot is stable for the whole access.

Optional Feature:
ACCESS_TIMEOUT_EN:
- Defined: a cycle counter runs in LOAD. After TIMEOUT_CYCLES cycles without load_ack, set timeout_err (sticky), drop load_req and return to IDLE.
- Undefined: LOAD waits indefinitely and timeout_err is tied to 0.

Test Plan:
- Reset mid-WINDOW (power_good low for 1 cycle) -> all outputs 0 immediately; position=0; state IDLE.
- Shift active, 10 field_ticks, replicator low for 5 cycles, bootloop=0 -> load_req with load_page=10, load_boot=1; ack after 20 cycles -> window opens after 100 ticks, stays open 584 ticks, bit_index runs 0..583.
- 2055 field_ticks with shift active -> position wraps and reads 2.
- Second replicator edge during DELAY -> overrun=1; first window still completes 584 bits.
- Shift released in WINDOW at bit_index=37 -> window closes next cycle, bit_index=0; a later load_ack produces no effect.
- With ACCESS_TIMEOUT_EN and TIMEOUT_CYCLES=50, no ack -> timeout_err=1 at cycle 50 of LOAD and load_req=0; without the macro, load_req is still 1 at cycle 1000.
